// File: rtl/instr_feeder_if.sv
// instr_feeder_if: execution-side handshake bundle between the instruction
// feeder (master) and the core (slave).
//   instr / instr_valid / instr_ready : instruction valid/ready handshake
//   pc                                : store address of the word in instr
//   redirect_valid / redirect_pc      : branch redirect request from the core
//   stop                              : core has executed a stop
//   instr_parity                      : XOR of instr bits, only when
//                                       INSTR_FEEDER_PARITY_EN is defined
interface instr_feeder_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 6
);
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [ADDR_W-1:0]  pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               stop;
`ifdef INSTR_FEEDER_PARITY_EN
  logic               instr_parity;

  modport master (
    output instr, instr_valid, pc, instr_parity,
    input  instr_ready, redirect_valid, redirect_pc, stop
  );
  modport slave (
    input  instr, instr_valid, pc, instr_parity,
    output instr_ready, redirect_valid, redirect_pc, stop
  );
`else
  modport master (
    output instr, instr_valid, pc,
    input  instr_ready, redirect_valid, redirect_pc, stop
  );
  modport slave (
    input  instr, instr_valid, pc,
    output instr_ready, redirect_valid, redirect_pc, stop
  );
`endif
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder: drives the core's instruction input from a loadable on-block
// instruction store. Presents one instruction per cycle over valid/ready,
// follows branch redirects and drains for STOP_DRAIN cycles after stop.
//
// Ports:
//   clk, n_reset (synchronous, active-low)
//   load_en_i/load_addr_i/load_data_i : store write port (IDLE/DONE only)
//   start_i                            : begin issuing from PC 0 (IDLE/DONE)
//   bus (instr_feeder_if.master)       : instr/valid/ready/pc, redirect, stop
//   busy_o                             : state is RUN or DRAIN
//   done_o                             : state is DONE
//   issued_count_o                     : accepted handshakes since start, saturating
//
// Optional: define INSTR_FEEDER_PARITY_EN to add bus.instr_parity, the even
// parity of instr registered alongside it.
module instr_feeder #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned STOP_DRAIN = 3
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               load_en_i,
  input  logic [ADDR_W-1:0]  load_addr_i,
  input  logic [INSTR_W-1:0] load_data_i,
  input  logic               start_i,
  instr_feeder_if.master     bus,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        issued_count_o
);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("instr_feeder: DEPTH must equal 2**ADDR_W");
  end
  if (STOP_DRAIN < 1 || STOP_DRAIN > 15) begin : g_bad_drain
    $error("instr_feeder: STOP_DRAIN must be 1..15");
  end

  localparam logic [3:0] DRAIN_LAST = 4'(STOP_DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fptr_q, fptr_d;
  logic [3:0]         drain_q, drain_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [15:0]        count_q, count_d;
`ifdef INSTR_FEEDER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic [INSTR_W-1:0] store_q [DEPTH];
  logic               store_we;
  logic               handshake;

  // Store is writable only while not issuing, so a running program never
  // observes a partially updated image.
  assign store_we  = n_reset && load_en_i && (state_q == S_IDLE || state_q == S_DONE);
  assign handshake = valid_q && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[load_addr_i] <= load_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    fptr_d  = fptr_q;
    drain_d = drain_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    count_d = count_q;
`ifdef INSTR_FEEDER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // The store write above lands on this same edge, and the first fetch
        // happens one cycle later in RUN, so a load with start is visible.
        if (start_i) begin
          state_d = S_RUN;
          fptr_d  = '0;
          count_d = '0;
        end
      end
      S_RUN: begin
        // A handshake coinciding with stop or redirect still counts.
        if (handshake && count_q != '1) begin
          count_d = count_q + 16'd1;
        end
        if (bus.stop) begin
          state_d = S_DRAIN;
          valid_d = 1'b0;
          drain_d = '0;
        end else if (bus.redirect_valid) begin
          valid_d = 1'b0;
          fptr_d  = bus.redirect_pc;
        end else if (!valid_q || bus.instr_ready) begin
          instr_d = store_q[fptr_q];
          pc_d    = fptr_q;
          valid_d = 1'b1;
          fptr_d  = fptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
`ifdef INSTR_FEEDER_PARITY_EN
          parity_d = ^store_q[fptr_q];
`endif
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      fptr_q  <= '0;
      drain_q <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
`ifdef INSTR_FEEDER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fptr_q  <= fptr_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      count_q <= count_d;
`ifdef INSTR_FEEDER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
`ifdef INSTR_FEEDER_PARITY_EN
  assign bus.instr_parity = parity_q;
`endif
  assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o         = (state_q == S_DONE);
  assign issued_count_o = count_q;

endmodule
